// File: rtl/serial_full_adder_if.sv
// Operand/result bundle for the bit-serial adder: start/ready/done handshake plus data.
`timescale 1ns/1ps
interface serial_full_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, sub, c_in,
    input  ready, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, sub, c_in,
    output ready, done, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// one result every WIDTH+2 cycles with sum, carry-out and signed overflow.
`timescale 1ns/1ps
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_full_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cOut_q, cOut_d;
  logic             ovf_q, ovf_d;
  logic             bitSum;
  logic             bitCarry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cOut_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cOut_q  <= cOut_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    res_d    = res_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cOut_d   = cOut_q;
    ovf_d    = ovf_q;
    bitSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    bitCarry = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);

    case (state_q)
      IDLE: begin
        // Subtraction is A + ~B + 1, so the caller's carry-in is overridden.
        if (bus.start) begin
          aSh_d   = bus.a;
          bSh_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = bitCarry;
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        res_d   = {bitSum, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + ONE;
        // carry_q is the carry into the MSB while the last bit is being added.
        if (cnt_q == LAST) begin
          cnt_d   = cnt_q;
          sum_d   = {bitSum, res_q[WIDTH-1:1]};
          cOut_d  = bitCarry;
          ovf_d   = carry_q ^ bitCarry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = cOut_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder at WIDTH 2, 8 and 32 against an
// arithmetic reference model; directed cases followed by randomized operations.
`timescale 1ns/1ps
module tb_serial_full_adder;

  typedef struct packed {
    logic        ready;
    logic        done;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] held [int];

  always #5 clk = ~clk;

  serial_full_adder_if #(.WIDTH(2))  if2 ();
  serial_full_adder_if #(.WIDTH(8))  if8 ();
  serial_full_adder_if #(.WIDTH(32)) if32 ();

  serial_full_adder #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));
  serial_full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_full_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  function automatic logic [31:0] maskOf(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Plain integer arithmetic: unsigned sum for sum/c_out, signed range test for ovf.
  function automatic void refModel(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit sub, input bit cin, output logic [31:0] sum,
                                   output bit co, output bit ov);
    longint unsigned modv;
    longint unsigned half;
    longint unsigned full;
    longint          sa;
    longint          sb;
    longint          sres;
    modv = 64'd1 << w;
    half = modv >> 1;
    if (sub) full = a + (modv - 64'd1 - b) + 64'd1;
    else     full = a + b + longint'(cin);
    sum  = 32'(full % modv);
    co   = (full >= modv);
    sa   = (a >= half) ? longint'(a) - longint'(modv) : longint'(a);
    sb   = (b >= half) ? longint'(b) - longint'(modv) : longint'(b);
    sres = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ov   = (sres > longint'(half) - 1) || (sres < -longint'(half));
  endfunction

  function automatic obs_t sample(input int w);
    obs_t o;
    o = '0;
    case (w)
      2: begin
        o.ready = if2.ready; o.done = if2.done; o.sum[1:0] = if2.sum;
        o.c_out = if2.c_out; o.ovf = if2.ovf;
      end
      8: begin
        o.ready = if8.ready; o.done = if8.done; o.sum[7:0] = if8.sum;
        o.c_out = if8.c_out; o.ovf = if8.ovf;
      end
      default: begin
        o.ready = if32.ready; o.done = if32.done; o.sum = if32.sum;
        o.c_out = if32.c_out; o.ovf = if32.ovf;
      end
    endcase
    return o;
  endfunction

  task automatic driveInputs(input int w, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic cin, input logic start);
    case (w)
      2: begin
        if2.a = a[1:0]; if2.b = b[1:0]; if2.sub = sub; if2.c_in = cin; if2.start = start;
      end
      8: begin
        if8.a = a[7:0]; if8.b = b[7:0]; if8.sub = sub; if8.c_in = cin; if8.start = start;
      end
      default: begin
        if32.a = a; if32.b = b; if32.sub = sub; if32.c_in = cin; if32.start = start;
      end
    endcase
  endtask

  task automatic driveStart(input int w, input logic start);
    case (w)
      2:       if2.start = start;
      8:       if8.start = start;
      default: if32.start = start;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input int w, input string tag);
    obs_t o;
    o = sample(w);
    checkOutput($sformatf("%s W%0d ready", tag, w), 32'(o.ready), 32'd1);
    checkOutput($sformatf("%s W%0d done",  tag, w), 32'(o.done),  32'd0);
    checkOutput($sformatf("%s W%0d sum",   tag, w), o.sum,        32'd0);
    checkOutput($sformatf("%s W%0d c_out", tag, w), 32'(o.c_out), 32'd0);
    checkOutput($sformatf("%s W%0d ovf",   tag, w), 32'(o.ovf),   32'd0);
  endtask

  // One full operation: start handshake, optional mid-run disturbance, latency and result checks.
  task automatic applyStimulus(input int w, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic cin, input bit interfere,
                               output obs_t res);
    logic [31:0] m;
    logic [31:0] eSum;
    bit          eCo;
    bit          eOv;
    int          k;
    int          waitCnt;
    obs_t        o;
    string       tag;
    m   = maskOf(w);
    tag = $sformatf("W%0d a=%0h b=%0h sub=%0b", w, a & m, b & m, sub);
    refModel(w, longint'(a & m), longint'(b & m), sub, cin, eSum, eCo, eOv);
    waitCnt = 0;
    o = sample(w);
    while (o.ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
      o = sample(w);
    end
    checkOutput({tag, " ready before start"}, 32'(o.ready), 32'd1);
    driveInputs(w, a, b, sub, cin, 1'b1);
    @(negedge clk);
    o = sample(w);
    checkOutput({tag, " ready low in run"}, 32'(o.ready), 32'd0);
    checkOutput({tag, " old sum held"}, o.sum, held[w]);
    k = 0;
    while (o.done !== 1'b1 && k < w + 4) begin
      if (interfere && k == 1) driveInputs(w, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ~sub, ~cin, 1'b1);
      else                     driveStart(w, 1'b0);
      @(negedge clk);
      k++;
      o = sample(w);
    end
    driveStart(w, 1'b0);
    checkOutput({tag, " done latency"}, 32'(k), 32'(w));
    checkOutput({tag, " done"},  32'(o.done),  32'd1);
    checkOutput({tag, " sum"},   o.sum,        eSum);
    checkOutput({tag, " c_out"}, 32'(o.c_out), 32'(eCo));
    checkOutput({tag, " ovf"},   32'(o.ovf),   32'(eOv));
    res = o;
    @(negedge clk);
    o = sample(w);
    checkOutput({tag, " done one cycle"}, 32'(o.done),  32'd0);
    checkOutput({tag, " ready after done"}, 32'(o.ready), 32'd1);
    checkOutput({tag, " sum held"}, o.sum, eSum);
    held[w] = eSum;
  endtask

  initial begin
    obs_t r;
    int   doneSeen;
    int   w;
    held[2] = 32'd0; held[8] = 32'd0; held[32] = 32'd0;
    driveInputs(2, 0, 0, 0, 0, 0);
    driveInputs(8, 0, 0, 0, 0, 0);
    driveInputs(32, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkReset(2, "reset");
    checkReset(8, "reset");
    checkReset(32, "reset");

    $display("[TB] directed additions");
    applyStimulus(8, 32'h3C, 32'h05, 1'b0, 1'b1, 1'b0, r);
    checkOutput("T1 sum", r.sum, 32'h42);
    applyStimulus(8, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, r);
    checkOutput("T2a sum", r.sum, 32'h00);
    checkOutput("T2a c_out", 32'(r.c_out), 32'd1);
    applyStimulus(8, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b0, r);
    checkOutput("T2b sum", r.sum, 32'h80);
    checkOutput("T2b ovf", 32'(r.ovf), 32'd1);

    $display("[TB] directed subtractions");
    applyStimulus(8, 32'h05, 32'h07, 1'b1, 1'b0, 1'b0, r);
    checkOutput("T3a sum", r.sum, 32'hFE);
    checkOutput("T3a c_out", 32'(r.c_out), 32'd0);
    applyStimulus(8, 32'h80, 32'h01, 1'b1, 1'b0, 1'b0, r);
    checkOutput("T3b sum", r.sum, 32'h7F);
    checkOutput("T3b c_out", 32'(r.c_out), 32'd1);
    checkOutput("T3b ovf", 32'(r.ovf), 32'd1);
    applyStimulus(8, 32'h05, 32'h07, 1'b1, 1'b1, 1'b0, r);
    checkOutput("T3c sum cin ignored", r.sum, 32'hFE);

    $display("[TB] interference during run");
    applyStimulus(8, 32'h10, 32'h20, 1'b0, 1'b0, 1'b1, r);
    checkOutput("T4 sum", r.sum, 32'h30);
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      r = sample(8);
      if (r.done === 1'b1) doneSeen++;
    end
    checkOutput("T4 no second op", 32'(doneSeen), 32'd0);
    checkOutput("T4 sum held", r.sum, 32'h30);

    $display("[TB] reset in the middle of an operation");
    driveInputs(8, 32'h55, 32'h11, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    driveStart(8, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held[2] = 32'd0; held[8] = 32'd0; held[32] = 32'd0;
    checkReset(8, "T5 abort");
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      r = sample(8);
      if (r.done === 1'b1) doneSeen++;
    end
    checkOutput("T5 no done pulse", 32'(doneSeen), 32'd0);
    applyStimulus(8, 32'h01, 32'h01, 1'b0, 1'b0, 1'b0, r);
    checkOutput("T5 sum after reset", r.sum, 32'h02);

    $display("[TB] narrow and wide instances");
    applyStimulus(2, 32'h3, 32'h1, 1'b0, 1'b0, 1'b0, r);
    checkOutput("T6 W2 sum", r.sum, 32'h0);
    checkOutput("T6 W2 c_out", 32'(r.c_out), 32'd1);
    applyStimulus(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, r);
    checkOutput("T6 W32 sum", r.sum, 32'h0);
    checkOutput("T6 W32 c_out", 32'(r.c_out), 32'd1);

    $display("[TB] randomized operations");
    for (int i = 0; i < 1000; i++) begin
      w = (i % 4 == 0) ? 2 : ((i % 4 == 1) ? 32 : 8);
      applyStimulus(w, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
